fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the F->D pipeline register. Holds the fetch PC,

---
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Holds the fetch PC, issues in-order reads to instruction
// memory over a req/gnt/rvalid handshake, and buffers returned words with their PCs
// in a small FIFO whose head drives instrF/PCF combinationally.
//
// outstanding_q counts every accepted request whose response has not yet arrived,
// including stale ones left over from a redirect; discard_q counts the stale subset.
// The pending-PC queue only holds PCs of live (non-stale) requests.
//
// Credit counts the head popped by weD in the same cycle as free. In steady state this
// lets the stage sustain one instruction per cycle at FIFO_DEPTH=2. The FIFO still
// cannot overflow, because the head is definitely popped at that edge.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        weD,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instrF,
    output logic [31:0] PCF,
    output logic        validF
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [31:0]   pend_pc_q [FIFO_DEPTH];
    logic [31:0]   pend_pc_d [FIFO_DEPTH];
    logic [PW-1:0] pend_wr_q, pend_wr_d;
    logic [PW-1:0] pend_rd_q, pend_rd_d;

    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_instr_d [FIFO_DEPTH];
    logic [PW-1:0] fifo_wr_q, fifo_wr_d;
    logic [PW-1:0] fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic          pop, issue, rsp_ok, rsp_keep, rsp_drop;
    logic [CW:0]   used;

    // Low address bits of the redirect target are forced to zero.
    logic [1:0]    unused_rpc_lsb;
    assign unused_rpc_lsb = redirect_pc[1:0];

    // Handshake decode, credit check and head presentation.
    always_comb begin
        validF    = (fifo_cnt_q != '0);
        pop       = weD & validF;
        used      = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q} - (CW+1)'(pop);
        imem_req  = reset & ~redirect & (used < (CW+1)'(FIFO_DEPTH));
        imem_addr = pc_q;
        issue     = imem_req & imem_gnt;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_ok    = imem_rvalid & (outstanding_q != '0);
        rsp_drop  = rsp_ok & (discard_q != '0);
        rsp_keep  = rsp_ok & (discard_q == '0);
        instrF    = validF ? fifo_instr_q[fifo_rd_q] : 32'h0;
        PCF       = validF ? fifo_pc_q[fifo_rd_q] : 32'h0;
    end

    // Next-state: issue, return, deliver, with redirect overriding everything.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        pend_pc_d     = pend_pc_q;
        pend_wr_d     = pend_wr_q;
        pend_rd_d     = pend_rd_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_cnt_d    = fifo_cnt_q;

        if (redirect) begin
            // Everything still in flight is stale; a word returning now is dropped here.
            pc_d          = {redirect_pc[31:2], 2'b00};
            outstanding_d = outstanding_q - CW'(rsp_ok);
            discard_d     = outstanding_q - CW'(rsp_ok);
            pend_wr_d     = '0;
            pend_rd_d     = '0;
            fifo_wr_d     = '0;
            fifo_rd_d     = '0;
            fifo_cnt_d    = '0;
        end else begin
            if (issue) begin
                pend_pc_d[pend_wr_q] = pc_q;
                pend_wr_d            = next_ptr(pend_wr_q);
                pc_d                 = pc_q + 32'd4;
            end
            if (rsp_keep) begin
                fifo_pc_d[fifo_wr_q]    = pend_pc_q[pend_rd_q];
                fifo_instr_d[fifo_wr_q] = imem_rdata;
                fifo_wr_d               = next_ptr(fifo_wr_q);
                pend_rd_d               = next_ptr(pend_rd_q);
            end
            if (rsp_drop) begin
                discard_d = discard_q - CW'(1);
            end
            if (pop) begin
                fifo_rd_d = next_ptr(fifo_rd_q);
            end
            outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_ok);
            fifo_cnt_d    = fifo_cnt_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            pend_wr_q     <= '0;
            pend_rd_q     <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                pend_pc_q[i]    <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            pend_pc_q     <= pend_pc_d;
            pend_wr_q     <= pend_wr_d;
            pend_rd_q     <= pend_rd_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_instr_q  <= fifo_instr_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Responses may only arrive for requests that were accepted.
    a_rvalid_has_credit: assert property (
        @(posedge clk) disable iff (!reset) imem_rvalid |-> (outstanding_q != '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory responder plus per-cycle
// expected outputs for the reset, streaming, stall, redirect and grant-stall cases.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        weD;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instrF;
    logic [31:0] PCF;
    logic        validF;

    logic        rv_en;
    logic [31:0] mem_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .weD         (weD),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instrF      (instrF),
        .PCF         (PCF),
        .validF      (validF)
    );

    // In-order memory: a grant is answered one cycle later unless rv_en holds it back.
    // Data returned for address A is A ^ KEY.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
            if (rv_en && mem_q.size() != 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_q.pop_front() ^ KEY;
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance to just past the edge.
    task automatic step(input string tag, input logic rst, input logic g, input logic w,
                        input logic rdr, input logic [31:0] rpc, input logic rv,
                        input logic e_req, input logic [31:0] e_addr, input logic e_v,
                        input logic [31:0] e_pc);
        reset       = rst;
        imem_gnt    = g;
        weD         = w;
        redirect    = rdr;
        redirect_pc = rpc;
        rv_en       = rv;
        @(negedge clk);
        check_eq({tag, " req"},    {31'b0, imem_req}, {31'b0, e_req});
        check_eq({tag, " addr"},   imem_addr, e_addr);
        check_eq({tag, " validF"}, {31'b0, validF}, {31'b0, e_v});
        check_eq({tag, " PCF"},    PCF, e_pc);
        check_eq({tag, " instrF"}, instrF, e_v ? (e_pc ^ KEY) : 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low: outputs quiet, fetch PC at reset value.
        step("rst0", 0, 1, 1, 0, 0, 1,   0, 32'h3000, 0, 32'h0);
        step("rst1", 0, 1, 1, 0, 0, 1,   0, 32'h3000, 0, 32'h0);

        // 1: streaming after reset release.
        step("t1c0", 1, 1, 1, 0, 0, 1,   1, 32'h3000, 0, 32'h0);
        step("t1c1", 1, 1, 1, 0, 0, 1,   1, 32'h3004, 0, 32'h0);
        step("t1c2", 1, 1, 1, 0, 0, 1,   1, 32'h3008, 1, 32'h3000);
        step("t1c3", 1, 1, 1, 0, 0, 1,   1, 32'h300C, 1, 32'h3004);

        // 2: decode stall for five cycles, FIFO fills, head frozen at 3008.
        step("t2c4", 1, 1, 0, 0, 0, 1,   0, 32'h3010, 1, 32'h3008);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("t2stall%0d", i), 1, 1, 0, 0, 0, 1, 0, 32'h3010, 1, 32'h3008);
        end
        step("t2c9",  1, 1, 1, 0, 0, 1,  1, 32'h3010, 1, 32'h3008);
        step("t2c10", 1, 1, 1, 0, 0, 0,  1, 32'h3014, 1, 32'h300C);

        // 3: redirect to 0x3401 while 3010 is popped and 3014 is still in flight.
        step("t3c11", 1, 1, 1, 1, 32'h0000_3401, 0,  0, 32'h3018, 1, 32'h3010);
        step("t3c12", 1, 1, 1, 0, 0, 0,  1, 32'h3400, 0, 32'h0);
        step("t3c13", 1, 1, 1, 0, 0, 1,  0, 32'h3404, 0, 32'h0);
        step("t3c14", 1, 1, 1, 0, 0, 1,  0, 32'h3404, 0, 32'h0);
        step("t3c15", 1, 1, 1, 0, 0, 1,  1, 32'h3404, 0, 32'h0);
        step("t3c16", 1, 1, 1, 0, 0, 1,  1, 32'h3408, 1, 32'h3400);
        step("t3c17", 1, 1, 1, 0, 0, 1,  1, 32'h340C, 1, 32'h3404);

        // 4: grant withheld for three cycles; address stable, FIFO drains to empty.
        step("t4c18", 1, 0, 1, 0, 0, 1,  1, 32'h3410, 1, 32'h3408);
        step("t4c19", 1, 0, 1, 0, 0, 1,  1, 32'h3410, 1, 32'h340C);
        step("t4c20", 1, 0, 1, 0, 0, 1,  1, 32'h3410, 0, 32'h0);
        step("t4c21", 1, 1, 1, 0, 0, 1,  1, 32'h3410, 0, 32'h0);
        step("t4c22", 1, 1, 1, 0, 0, 1,  1, 32'h3414, 0, 32'h0);
        step("t4c23", 1, 1, 1, 0, 0, 1,  1, 32'h3418, 1, 32'h3410);

        // 5: redirect coincident with the only outstanding response (3418 dropped).
        step("t5c24", 1, 1, 1, 1, 32'h0000_5006, 1,  0, 32'h341C, 1, 32'h3414);
        step("t5c25", 1, 1, 1, 0, 0, 1,  1, 32'h5004, 0, 32'h0);
        step("t5c26", 1, 1, 1, 0, 0, 1,  1, 32'h5008, 0, 32'h0);
        step("t5c27", 1, 1, 1, 0, 0, 1,  1, 32'h500C, 1, 32'h5004);

        // 6: fill the FIFO, then assert reset mid-cycle and restart.
        step("t6c28", 1, 1, 0, 0, 0, 1,  0, 32'h5010, 1, 32'h5008);
        step("t6c29", 1, 1, 0, 0, 0, 1,  0, 32'h5010, 1, 32'h5008);
        step("t6c30", 0, 1, 0, 0, 0, 1,  0, 32'h3000, 0, 32'h0);
        step("t6c31", 0, 1, 1, 0, 0, 1,  0, 32'h3000, 0, 32'h0);
        step("t6c32", 1, 1, 1, 0, 0, 1,  1, 32'h3000, 0, 32'h0);
        step("t6c33", 1, 1, 1, 0, 0, 1,  1, 32'h3004, 0, 32'h0);
        step("t6c34", 1, 1, 1, 0, 0, 1,  1, 32'h3008, 1, 32'h3000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
